// File: rtl/imsic_pkg.sv
// Shared IMSIC constants: interrupt-file page geometry, seteipnum offsets, byte-swap helper.
package imsic_pkg;

    localparam int unsigned INTP_FILE_PAGE_SHIFT = 12;
    localparam logic [11:0] SETEIPNUM_LE_OFF     = 12'h000;
    localparam logic [11:0] SETEIPNUM_BE_OFF     = 12'h004;

    function automatic logic [31:0] bswap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/imsic_msi_sync_fifo.sv
// Single-clock circular-buffer FIFO with valid/ready pop and an occupancy count.
module imsic_msi_sync_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     rd_vld,
    output logic [WIDTH-1:0]         rd_data,
    input  logic                     rd_rdy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             full;
    logic             push;
    logic             pop;

    assign full   = (32'(count_q) == DEPTH);
    assign pop    = rd_rdy && (count_q != '0);
    // A pop in the same cycle frees the slot, so push at full is accepted.
    assign push   = wr_en && (!full || pop);
    assign rd_vld = (count_q != '0);
    assign rd_data = rd_vld ? mem_q[rd_ptr_q] : '0;
    assign count  = count_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (!(wr_en && full && !pop))
            else $error("imsic_msi_sync_fifo: push into full FIFO");
        end
    end
`endif

endmodule

// File: rtl/imsic_msi_decode_fifo.sv
// Decodes AXI-lite seteipnum writes into MSIs {file, id}, queues them, and throttles the slave.
module imsic_msi_decode_fifo
    import imsic_pkg::*;
#(
    parameter int unsigned  AXI_ADDR_WIDTH = 32,
    parameter int unsigned  NR_INTP_FILES  = 7,
    parameter int unsigned  NR_SRC         = 64,
    parameter int unsigned  FIFO_DEPTH     = 4,
    localparam int unsigned FILE_W         = $clog2(NR_INTP_FILES),
    localparam int unsigned SRC_W          = $clog2(NR_SRC)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      reg_wr,
    input  logic [AXI_ADDR_WIDTH-1:0] reg_waddr,
    input  logic [31:0]               reg_wdata,
    output logic                      addr_is_illegal,
    output logic                      fifo_wr,
    output logic                      msi_recv_vld,
    output logic                      msi_vld_o,
    output logic [FILE_W-1:0]         msi_file_o,
    output logic [SRC_W-1:0]          msi_id_o,
    input  logic                      msi_rdy_i
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [FILE_W-1:0]       file;
    logic [11:0]             off;
    logic                    high_nz;
    logic [31:0]             id32;

    logic                    dec_vld_q;
    logic [FILE_W-1:0]       dec_file_q;
    logic [31:0]             dec_id32_q;
    logic                    id_ok;
    logic                    push;

    logic                    hold_q;
    logic                    hold_d;
    logic [CNT_W-1:0]        fifo_count;
    logic [FILE_W+SRC_W-1:0] head;

    assign file    = reg_waddr[INTP_FILE_PAGE_SHIFT +: FILE_W];
    assign off     = reg_waddr[11:0];
    assign high_nz = (reg_waddr >> (INTP_FILE_PAGE_SHIFT + FILE_W)) != '0;

    assign addr_is_illegal = (32'(file) >= NR_INTP_FILES) || high_nz ||
                             ((off != SETEIPNUM_LE_OFF) && (off != SETEIPNUM_BE_OFF));

    assign id32 = (off == SETEIPNUM_BE_OFF) ? bswap32(reg_wdata) : reg_wdata;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            dec_vld_q  <= 1'b0;
            dec_file_q <= '0;
            dec_id32_q <= '0;
        end else begin
            dec_vld_q <= reg_wr && !addr_is_illegal;
            if (reg_wr) begin
                dec_file_q <= file;
                dec_id32_q <= id32;
            end
        end
    end

    // Out-of-range identities still complete the write but never reach the queue.
    assign id_ok   = (dec_id32_q != '0) && (dec_id32_q < NR_SRC);
    assign push    = dec_vld_q && id_ok;
    assign fifo_wr = dec_vld_q;

    // hold reserves a FIFO slot from slave acceptance until the write resolves.
    assign msi_recv_vld = rstn && !dec_vld_q && !reg_wr &&
                          ((32'(fifo_count) + 32'(hold_q)) < FIFO_DEPTH);

    always_comb begin
        hold_d = hold_q;
        if (msi_recv_vld) begin
            hold_d = 1'b1;
        end
        if (fifo_wr || (reg_wr && addr_is_illegal)) begin
            hold_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            hold_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
        end
    end

    imsic_msi_sync_fifo #(
        .WIDTH (FILE_W + SRC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (push),
        .wr_data ({dec_file_q, dec_id32_q[SRC_W-1:0]}),
        .rd_vld  (msi_vld_o),
        .rd_data (head),
        .rd_rdy  (msi_rdy_i),
        .count   (fifo_count)
    );

    assign msi_file_o = head[SRC_W +: FILE_W];
    assign msi_id_o   = head[SRC_W-1:0];

endmodule

// File: tb/tb_imsic_msi_decode_fifo.sv
// Randomised scoreboard bench for imsic_msi_decode_fifo against a page/offset reference model.
`timescale 1ns/1ps
module tb_imsic_msi_decode_fifo;

    localparam int unsigned NR_FILES = 7;
    localparam int unsigned NR_SRC   = 64;
    localparam int unsigned DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        reg_wr = 1'b0;
    logic [31:0] reg_waddr = '0;
    logic [31:0] reg_wdata = '0;
    logic        addr_is_illegal;
    logic        fifo_wr;
    logic        msi_recv_vld;
    logic        msi_vld_o;
    logic [2:0]  msi_file_o;
    logic [5:0]  msi_id_o;
    logic        msi_rdy_i = 1'b0;

    int          checks = 0;
    int          passed = 0;
    bit          rand_rdy = 1'b0;
    logic [8:0]  exp_q[$];

    always #5 clk = ~clk;

    imsic_msi_decode_fifo #(
        .AXI_ADDR_WIDTH (32),
        .NR_INTP_FILES  (NR_FILES),
        .NR_SRC         (NR_SRC),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .reg_wr          (reg_wr),
        .reg_waddr       (reg_waddr),
        .reg_wdata       (reg_wdata),
        .addr_is_illegal (addr_is_illegal),
        .fifo_wr         (fifo_wr),
        .msi_recv_vld    (msi_recv_vld),
        .msi_vld_o       (msi_vld_o),
        .msi_file_o      (msi_file_o),
        .msi_id_o        (msi_id_o),
        .msi_rdy_i       (msi_rdy_i)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Legal iff the 4 KiB page index names an existing file and the offset is LE or BE.
    function automatic bit mdl_legal(input logic [31:0] a);
        int unsigned page = a / 4096;
        int unsigned off  = a % 4096;
        return (page < NR_FILES) && (off == 0 || off == 4);
    endfunction

    // Monitor: every handshake pops the oldest expected MSI.
    always @(negedge clk) begin
        if (rstn && msi_vld_o && msi_rdy_i) begin
            if (exp_q.size() == 0) chk("unexpected_msi", 64'(exp_q.size()), 64'(1));
            else chk("msi_head", 64'({msi_file_o, msi_id_o}), 64'(exp_q.pop_front()));
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            msi_rdy_i = 1'($urandom_range(0, 1));
        end
    end

    task automatic axi_wr(input logic [31:0] a, input logic [31:0] d, input bit pop_on_commit);
        int          n = 0;
        bit          legal;
        logic [31:0] id;
        do begin
            @(negedge clk);
            n++;
        end while (msi_recv_vld !== 1'b1 && n < 64);
        if (msi_recv_vld !== 1'b1) begin
            chk("recv_vld_timeout", 64'(msi_recv_vld), 64'(1));
            return;
        end
        legal = mdl_legal(a);
        id = d;
        if (a % 4096 == 4) id = {<<8{d}};
        @(posedge clk);
        #1;
        reg_wr = 1'b1;
        reg_waddr = a;
        reg_wdata = d;
        if (legal && id != 0 && id < NR_SRC) exp_q.push_back({3'(a / 4096), 6'(id)});
        @(negedge clk);
        chk("addr_is_illegal", 64'(addr_is_illegal), 64'(!legal));
        @(posedge clk);
        #1;
        reg_wr = 1'b0;
        if (pop_on_commit) msi_rdy_i = 1'b1;
        @(negedge clk);
        chk("fifo_wr", 64'(fifo_wr), 64'(legal));
        if (pop_on_commit) begin
            @(posedge clk);
            #1;
            msi_rdy_i = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        @(posedge clk);
        #1;
        msi_rdy_i = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || msi_vld_o) && n < 64);
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
        chk("drain_vld", 64'(msi_vld_o), 64'(0));
        @(posedge clk);
        #1;
        msi_rdy_i = 1'b0;
    endtask

    initial begin
        logic [31:0] ill_addr [3];
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] id;
        ill_addr[0] = 32'h0000_7000;
        ill_addr[1] = 32'h0000_0008;
        ill_addr[2] = 32'h0001_0000;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_recv_vld", 64'(msi_recv_vld), 64'(0));
        chk("rst_fifo_wr", 64'(fifo_wr), 64'(0));
        chk("rst_msi_vld", 64'(msi_vld_o), 64'(0));
        chk("rst_head", 64'({msi_file_o, msi_id_o}), 64'(0));
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("recv_vld_after_rst", 64'(msi_recv_vld), 64'(1));

        // LE write, exact latency
        axi_wr(32'h0000_1000, 32'h5, 1'b0);
        chk("le_vld_t1", 64'(msi_vld_o), 64'(0));
        @(negedge clk);
        chk("le_vld_t2", 64'(msi_vld_o), 64'(1));
        chk("le_file", 64'(msi_file_o), 64'(1));
        chk("le_id", 64'(msi_id_o), 64'(5));
        chk("fifo_wr_one_cycle", 64'(fifo_wr), 64'(0));
        drain();

        // BE write
        axi_wr(32'h0000_0004, 32'h0A00_0000, 1'b0);
        @(negedge clk);
        chk("be_vld", 64'(msi_vld_o), 64'(1));
        chk("be_file", 64'(msi_file_o), 64'(0));
        chk("be_id", 64'(msi_id_o), 64'(10));
        drain();

        // Illegal decodes and dropped identities never reach the queue
        for (int i = 0; i < 3; i++) axi_wr(ill_addr[i], 32'h5, 1'b0);
        axi_wr(32'h0000_0000, 32'd0, 1'b0);
        axi_wr(32'h0000_0000, 32'd64, 1'b0);
        repeat (2) @(negedge clk);
        chk("no_push_illegal_or_drop", 64'(msi_vld_o), 64'(0));

        // Fill the queue, then free one slot
        for (int i = 0; i < 4; i++) axi_wr(32'(i) * 32'h1000, 32'(i + 20), 1'b0);
        @(negedge clk);
        chk("full_recv_low", 64'(msi_recv_vld), 64'(0));
        chk("full_vld", 64'(msi_vld_o), 64'(1));
        @(negedge clk);
        chk("full_recv_low2", 64'(msi_recv_vld), 64'(0));
        @(posedge clk);
        #1;
        msi_rdy_i = 1'b1;
        @(posedge clk);
        #1;
        msi_rdy_i = 1'b0;
        @(negedge clk);
        chk("recv_after_pop", 64'(msi_recv_vld), 64'(1));

        // Random traffic with random consumer backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = 32'($urandom_range(0, 7)) << 12;
            case ($urandom_range(0, 5))
                0, 2:    a = a | 32'h0;
                1, 3:    a = a | 32'h4;
                4:       a = a | 32'h8;
                default: a = a | ($urandom & 32'hffc);
            endcase
            if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(15, 31));
            case ($urandom_range(0, 5))
                0:       id = 32'd0;
                1:       id = 32'($urandom_range(64, 300));
                default: id = 32'($urandom_range(1, 63));
            endcase
            d = id;
            if (a[11:0] == 12'h004) d = {<<8{id}};
            axi_wr(a, d, 1'b0);
        end
        rand_rdy = 1'b0;
        drain();

        // Push and pop in the same cycle at one entry
        axi_wr(32'h0000_2000, 32'd7, 1'b0);
        axi_wr(32'h0000_3004, 32'h0900_0000, 1'b1);
        @(negedge clk);
        chk("pp_vld", 64'(msi_vld_o), 64'(1));
        chk("pp_head", 64'({msi_file_o, msi_id_o}), 64'({3'd3, 6'd9}));
        @(posedge clk);
        #1;
        msi_rdy_i = 1'b1;
        @(posedge clk);
        #1;
        msi_rdy_i = 1'b0;
        @(negedge clk);
        chk("pp_count_one", 64'(msi_vld_o), 64'(0));

        // Mid-operation reset with three entries queued
        axi_wr(32'h0000_0000, 32'd1, 1'b0);
        axi_wr(32'h0000_5000, 32'd2, 1'b0);
        axi_wr(32'h0000_6004, 32'h0300_0000, 1'b0);
        @(negedge clk);
        chk("three_queued_vld", 64'(msi_vld_o), 64'(1));
        @(posedge clk);
        #1;
        rstn = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_recv_low", 64'(msi_recv_vld), 64'(0));
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("midrst_vld", 64'(msi_vld_o), 64'(0));
        chk("midrst_fifo_wr", 64'(fifo_wr), 64'(0));
        chk("midrst_head", 64'({msi_file_o, msi_id_o}), 64'(0));
        chk("midrst_recv_vld", 64'(msi_recv_vld), 64'(1));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end

endmodule

// File: doc/imsic_msi_decode_fifo.md
# imsic_msi_decode_fifo

Downstream stage of the IMSIC AXI-lite slave: it takes the single-beat register write (`reg_wr`/`reg_waddr`/`reg_wdata`) and decodes it as a `seteipnum_le`/`seteipnum_be` MSI to one of `NR_INTP_FILES` interrupt files. It reports address legality and write completion back to the AXI slave and queues legal MSIs `{file, id}` in a small FIFO, which the interrupt-file logic drains with valid/ready. It also throttles the AXI slave through `msi_recv_vld` so a queued MSI is never lost.

## Interface
Parameters:
- `AXI_ADDR_WIDTH`, 32: width of `reg_waddr`; base-relative address.
- `NR_INTP_FILES`, 7: number of interrupt files, one 4 KiB page each.
- `NR_SRC`, 64: number of interrupt identities per file; IDs 1..`NR_SRC`-1 are valid.
- `FIFO_DEPTH`, 4: MSI queue entries; power of two, at least 2.

Derived values: `FILE_W` = clog2(`NR_INTP_FILES`), `SRC_W` = clog2(`NR_SRC`).

Ports:
- `clk`  in  1  clock
- `rstn`  in  1  reset. One clock; reset is synchronous and active-low.
- `reg_wr`  in  1  one-cycle write strobe from the AXI slave.
- `reg_waddr`  in  `AXI_ADDR_WIDTH`  write address; stable while `reg_wr` is high.
- `reg_wdata`  in  32  write data.
- `addr_is_illegal`  out  1  combinational decode of `reg_waddr`.
- `fifo_wr`  out  1  registered pulse meaning "legal write consumed".
- `msi_recv_vld`  out  1  the AXI slave may accept a new transaction.
- `msi_vld_o`  out  1  FIFO head valid.
- `msi_file_o`  out  `FILE_W`  head file index.
- `msi_id_o`  out  `SRC_W`  head interrupt ID.
- `msi_rdy_i`  in  1  consumer pops the head when `msi_vld_o` and `msi_rdy_i` are both high.

## Operation
- Address fields: `file` = `reg_waddr[12+FILE_W-1:12]`; `off` = `reg_waddr[11:0]`.
- `addr_is_illegal` = 1 when any of the following holds:
  - `file` ≥ `NR_INTP_FILES`;
  - any `reg_waddr` bit above `12+FILE_W-1` is nonzero;
  - `off` ∉ {0x000, 0x004}.
- ID extraction:
  - `off` = 0x000 (LE): `id32` = `reg_wdata`.
  - `off` = 0x004 (BE): `id32` = `reg_wdata` byte-reversed.
- Decode stage: on `reg_wr & ~addr_is_illegal`, register `dec_vld` = 1, `dec_file`, `dec_id32`.
- Commit stage: in the cycle `dec_vld` is 1, `fifo_wr` = 1.
  - If `dec_id32` ≠ 0 and `dec_id32` < `NR_SRC`, push `{dec_file, dec_id32[SRC_W-1:0]}`.
  - Otherwise drop the write silently; `fifo_wr` still pulses so AXI returns OKAY.
- Illegal writes never set `dec_vld`. The AXI slave completes them with DECERR on its own.
- `msi_recv_vld` = `rstn` & ~`dec_vld` & ~`reg_wr` & (`count` + `hold` < `FIFO_DEPTH`).
  - `hold` = 1 from the AXI slave's acceptance until `fifo_wr` or an illegal `reg_wr`. Track it internally by setting on `msi_recv_vld` and clearing on the commit / illegal-write cycle.
  - This guarantees every legal commit finds a free entry; a push into a full FIFO is impossible. Flag one with a simulation-only assertion.
- FIFO: circular buffer with `clog2(FIFO_DEPTH)`-bit read/write pointers that wrap modulo depth, plus `count` of width `clog2(FIFO_DEPTH)+1`.
  - Simultaneous push and pop: `count` unchanged, both pointers advance. This is legal at any occupancy, including full and one-entry.
  - Pop when empty: ignored.
- Reset (synchronous, applies mid-operation): pointers, `count`, `dec_vld`, `hold` cleared. Queued and in-flight MSIs are discarded.

## Timing
- Reset values: `fifo_wr`=0, `msi_vld_o`=0, `msi_file_o`=0, `msi_id_o`=0, `addr_is_illegal`=combinational, `msi_recv_vld`=0 while `rstn` is low and 1 on the first cycle after.
- `addr_is_illegal`: zero latency; the AXI slave samples it in the `reg_wr` cycle.
- `fifo_wr`: cycle T+1 for `reg_wr` at T; exactly one cycle wide.
- Push at T+1 makes `msi_vld_o` high at T+2 (registered FIFO outputs). Total MSI latency is 2 cycles from `reg_wr`.
- `msi_*_o` are stable while `msi_vld_o & ~msi_rdy_i`.
- Throughput: one MSI per AXI write transaction; pop at most one per cycle.

## Structure
- Shared package `imsic_pkg`: `SETEIPNUM_LE_OFF`=12'h000, `SETEIPNUM_BE_OFF`=12'h004, `INTP_FILE_PAGE_SHIFT`=12.
- Sub-module `imsic_msi_sync_fifo` (parameters `WIDTH`, `DEPTH`): generic single-clock FIFO with valid/ready pop, `count` output, and synchronous active-low reset.
- Top level holds address decode, byte swap, decode register, and `hold`/`msi_recv_vld` logic.

## Test plan
- LE write: `reg_waddr`=0x1000, `wdata`=0x05 → `addr_is_illegal`=0, `fifo_wr` at T+1, head {file 1, id 5} at T+2.
- BE write: `reg_waddr`=0x0004, `wdata`=0x0A000000 → head {file 0, id 10}.
- Illegal decode cases → `addr_is_illegal`=1, no `fifo_wr`, no push:
  - `reg_waddr`=0x7000 (file 7 ≥ 7);
  - 0x0008;
  - 0x10000.
- Silently dropped IDs: `wdata`=0 and `wdata`=64 at 0x0000 → `fifo_wr` pulses, `count` stays 0.
- Full queue: 4 legal writes with `msi_rdy_i`=0 → `count`=4, `msi_recv_vld`=0. Then `msi_rdy_i`=1 for one cycle → `count`=3, `msi_recv_vld`=1. Then 20 random writes with random `msi_rdy_i` → in-order delivery, pointer wrap, no loss.
- Simultaneous push/pop at `count`=1, and `rstn` low for one cycle with 3 entries queued → `count` unchanged by the push/pop, then 0 after reset; `msi_vld_o`=0 and `fifo_wr`=0 the next cycle.
